code_lock: RTL

Parametrised successor to the single-attempt digital lock FSM. It collects a start-keyed entry of `DIGITS` digits and compares it against a code captured at entry start. It reveals a mismatch only after the full entry is in, allows `MAX_TRIES` attempts with a timed lockout between failures, and relocks automatically after a programmable open time. It sits between the keypad decoder (one-cycle key strobes) and the actuator/alarm drivers.

---
 rtl/lock_pkg.sv | 20 ++
 rtl/lock_timer.sv | 23 ++
 rtl/code_lock.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared state encoding and key command definitions for the code lock.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    LOCKOUT = 3'd2,
    OPEN    = 3'd3,
    ALARM   = 3'd4
  } state_t;

  localparam int START_OFS = 0;
  localparam int CLEAR_OFS = 1;

  // Command keys sit just above the digit range.
  function automatic int cmd_key(input int digit_w, input int ofs);
    return (1 << digit_w) + ofs;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the OPEN hold time and the LOCKOUT delay.
module lock_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/code_lock.sv
// Multi-digit code lock: start-keyed entry, deferred mismatch reveal, limited
// tries with timed lockout, auto-relock after the open time, absorbing alarm.
module code_lock
  import lock_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int DIGIT_W        = 4,
  parameter int KEY_W          = 5,
  parameter int MAX_TRIES      = 3,
  parameter int OPEN_CYCLES    = 1000,
  parameter int LOCKOUT_CYCLES = 500
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [KEY_W-1:0]               key,
  input  logic                           key_valid,
  input  logic [DIGITS*DIGIT_W-1:0]      seq,
  output logic [2:0]                     state,
  output logic [$clog2(DIGITS+1)-1:0]    digit_idx,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic                           unlock,
  output logic                           alarm
);

  localparam int IDX_W   = $clog2(DIGITS+1);
  localparam int TRY_W   = $clog2(MAX_TRIES+1);
  localparam int TMAX    = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_W = $clog2(TMAX+1);

  localparam logic [KEY_W-1:0] K_START = KEY_W'(cmd_key(DIGIT_W, START_OFS));
  localparam logic [KEY_W-1:0] K_CLEAR = KEY_W'(cmd_key(DIGIT_W, CLEAR_OFS));

  state_t                           st;
  logic [DIGITS-1:0][DIGIT_W-1:0]   shadow;
  logic                             err;

  logic                             is_start, is_clear, is_digit;
  logic                             last, digit_err;
  logic [DIGIT_W-1:0]               exp_digit;
  logic                             timer_load, timer_dec, timer_zero;
  logic [TIMER_W-1:0]               timer_val;

  assign is_start = key_valid && (key == K_START);
  assign is_clear = key_valid && (key == K_CLEAR);
  assign is_digit = key_valid && (key[KEY_W-1:DIGIT_W] == '0);
  assign last     = (digit_idx == IDX_W'(DIGITS-1));

  // Digit expected at the current position; first digit lives in the MS slice.
  always_comb begin
    exp_digit = '0;
    for (int i = 0; i < DIGITS; i++)
      if (digit_idx == IDX_W'(i)) exp_digit = shadow[DIGITS-1-i];
  end

  assign digit_err = err | (key[DIGIT_W-1:0] != exp_digit);

  assign timer_load = (st == ENTRY) && is_digit && last &&
                      (!digit_err || tries_left != TRY_W'(1));
  assign timer_val  = digit_err ? TIMER_W'(LOCKOUT_CYCLES-1) : TIMER_W'(OPEN_CYCLES-1);
  assign timer_dec  = (st == LOCKOUT) || (st == OPEN && !is_start && !is_clear);

  lock_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      digit_idx  <= '0;
      tries_left <= TRY_W'(MAX_TRIES);
      err        <= 1'b0;
      shadow     <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (is_start) begin
            st        <= ENTRY;
            shadow    <= seq;
            digit_idx <= '0;
            err       <= 1'b0;
          end
        end
        ENTRY: begin
          if (is_start) begin
            shadow    <= seq;
            digit_idx <= '0;
            err       <= 1'b0;
          end else if (is_clear) begin
            st        <= IDLE;
            digit_idx <= '0;
          end else if (is_digit) begin
            digit_idx <= digit_idx + 1'b1;
            err       <= digit_err;
            if (last) begin
              if (!digit_err) begin
                st         <= OPEN;
                tries_left <= TRY_W'(MAX_TRIES);
              end else if (tries_left == TRY_W'(1)) begin
                st         <= ALARM;
                tries_left <= '0;
              end else begin
                st         <= LOCKOUT;
                tries_left <= tries_left - 1'b1;
              end
            end
          end
        end
        LOCKOUT: begin
          if (timer_zero) st <= IDLE;
        end
        OPEN: begin
          // A key in the expiry cycle takes priority over auto-relock.
          if (is_start) begin
            st        <= ENTRY;
            shadow    <= seq;
            digit_idx <= '0;
            err       <= 1'b0;
          end else if (is_clear) begin
            st        <= IDLE;
            digit_idx <= '0;
          end else if (timer_zero) begin
            st <= IDLE;
          end
        end
        ALARM: st <= ALARM;
        default: st <= IDLE;
      endcase
    end
  end

  assign state  = st;
  assign unlock = (st == OPEN);
  assign alarm  = (st == ALARM);

endmodule
